muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit, a parametrised multi-cycle sibling of the single-cycle integer ALU in the execute stage. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation through a valid/ready handshake and computes BITS_PER_CYCLE result bits per clock. It returns the result with its destination tag through a second valid/ready handshake. The execute stage uses busy_out to stall and flush_in to squash on a downstream JUMP.

Parameters:
XLEN, 32, operand/result width; must be a multiple of BITS_PER_CYCLE.
BITS_PER_CYCLE, 1, quotient/multiplier bits processed per iteration (1, 2 or 4); N = XLEN/BITS_PER_CYCLE iterations.
EARLY_OUT, 1, when 1, divide-by-zero and signed overflow complete without iterating.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
flush_in  in  1  synchronous squash of any in-flight or completed operation
valid_in  in  1  operation request
ready_out  out  1  unit can accept the request this cycle
op_in  in  3  RV32M funct3 encoding (muldiv_pkg::op_t)
a_in  in  XLEN  rs1 operand
b_in  in  XLEN  rs2 operand
rd_in  in  5  destination register tag
valid_out  out  1  result available
ready_in  in  1  consumer accepts the result
result_out  out  XLEN  result
rd_out  out  5  tag captured with the operation
busy_out  out  1  high in BUSY and FIX states

Behaviour:
- States: IDLE, BUSY, FIX, DONE.
- Reset (rst_n low, effective immediately): state=IDLE; valid_out=0, busy_out=0, result_out=0, rd_out=0, iteration counter=0. ready_out is forced 0 while rst_n is low.
- ready_out = (state==IDLE) || (state==DONE && ready_in). It never depends on valid_in or flush_in.
- Accept edge (E0): valid_in && ready_out && !flush_in.
  - Latch op, rd, and the operand sign flags.
  - Latch |a| and |b| according to op signedness: MULH and DIV/REM signed on both operands; MULHSU signed on a only; MUL uses the low product bits so signedness is irrelevant.
  - Load the counter with N-1 and go to BUSY.
- BUSY: each edge performs one muldiv_step.
  - Multiply: BITS_PER_CYCLE shift-add steps into a 2*XLEN accumulator.
  - Divide: BITS_PER_CYCLE restoring subtract steps.
  - At counter==0 go to FIX.
- FIX (one edge): negate the product or quotient/remainder as required, then select the output.
  - MUL: low XLEN bits. MULH/MULHSU/MULHU: high XLEN bits. DIV/DIVU: quotient. REM/REMU: remainder.
  - Remainder takes the sign of the dividend. Register result_out, go to DONE.
- Latency: valid_out is high after edge E(N+1), i.e. 33 cycles for XLEN=32, BITS_PER_CYCLE=1, and 9 cycles for BITS_PER_CYCLE=4.
- Special cases (RISC-V mandated; results are identical whatever EARLY_OUT is set to):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (a = -2^(XLEN-1), b = -1): DIV = a; REM = 0.
  - With EARLY_OUT=1, the accept edge goes straight to DONE with the result, so latency is 1. Otherwise the full N+1 latency applies.
- DONE: valid_out=1; result_out and rd_out stay stable until a handshake.
  - On valid_out && ready_in: with valid_in and no flush, accept the new op in the same edge; otherwise go to IDLE.
- flush_in:
  - In any state, the next edge enters IDLE and clears valid_out; the partial state is discarded.
  - flush_in has priority over accept and over the output handshake.
  - flush_in in IDLE is a no-op.
- result_out holds its last value in IDLE and BUSY, and is only updated in FIX or on an early-out.
- Arithmetic: magnitudes are unsigned XLEN-bit; |(-2^(XLEN-1))| = 2^(XLEN-1) is representable as unsigned. Negation is two's complement modulo the width.

Decomposition:
- muldiv_pkg holds: op_t enum (MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7), state_t enum, and helpers is_div(op) and a_signed/b_signed(op).
- One sub-module, muldiv_step: combinational, with BITS_PER_CYCLE unrolled shift-add or restoring-subtract iterations, parametrised by XLEN and BITS_PER_CYCLE.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, rd_out=rd_in. valid_out rises exactly 33 cycles after accept (9 with BITS_PER_CYCLE=4).
2. High multiplies:
   - MULH 0x80000000 x 0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. Divides:
   - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
   - REM same operands -> 0xFFFFFFFF.
   - DIVU 0xFFFFFFFE / 2 -> 0x7FFFFFFF.
   - REMU 17 / 5 -> 2.
4. Special cases:
   - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
   - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
   - Latency 1 with EARLY_OUT=1, 33 with EARLY_OUT=0.
5. Backpressure: hold ready_in=0 for 10 cycles in DONE -> result_out and rd_out stable, ready_out=0. Then raise ready_in=1 with valid_in=1 -> the result is consumed and the next op accepted on the same edge, with no idle cycle.
6. Flush and reset:
   - Assert flush_in in the 10th BUSY cycle of a DIV -> valid_out never rises; the unit is IDLE with ready_out=1 on the next cycle.
   - Drop rst_n mid-MUL -> valid_out, busy_out, result_out and ready_out go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and operation decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic is_div(op_t op);
      return op inside {DIV, DIVU, REM, REMU};
   endfunction

   function automatic logic a_signed(op_t op);
      return op inside {MULH, MULHSU, DIV, REM};
   endfunction

   function automatic logic b_signed(op_t op);
      return op inside {MULH, DIV, REM};
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration group: BITS_PER_CYCLE unrolled shift-add (multiply) or restoring-subtract (divide) steps.
module muldiv_step #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                div,
   input  logic [2*XLEN-1:0]   acc,
   input  logic [XLEN-1:0]     b,
   output logic [2*XLEN-1:0]   acc_next
);

   logic [2*XLEN-1:0] work;
   logic [XLEN:0]     sum;
   logic [XLEN:0]     diff;

   // Multiply: acc = {partial high, remaining multiplier}; divide: acc = {remainder, dividend/quotient}.
   always_comb begin
      work = acc;
      sum  = '0;
      diff = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (div) begin
            diff = work[2*XLEN-1:XLEN-1] - {1'b0, b};
            if (!diff[XLEN])
               work = {diff[XLEN-1:0], work[XLEN-2:0], 1'b1};
            else
               work = {work[2*XLEN-2:0], 1'b0};
         end else begin
            sum  = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, b} : {(XLEN+1){1'b0}});
            work = {sum, work[XLEN-1:1]};
         end
      end
      acc_next = work;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready on both sides, flush and optional early-out.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter bit EARLY_OUT      = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_in,
   input  logic            valid_in,
   output logic            ready_out,
   input  op_t             op_in,
   input  logic [XLEN-1:0] a_in,
   input  logic [XLEN-1:0] b_in,
   input  logic [4:0]      rd_in,
   output logic            valid_out,
   input  logic            ready_in,
   output logic [XLEN-1:0] result_out,
   output logic [4:0]      rd_out,
   output logic            busy_out
);

   localparam int N     = XLEN / BITS_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state, state_d;
   op_t               op_q;
   logic              a_neg, b_neg, b_zero;
   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] acc, acc_step, prod;
   logic [XLEN-1:0]   b_mag;
   logic              accept, load, step, fix, early, early_hit, div_op;
   logic              a_neg_in, b_neg_in;
   logic [XLEN-1:0]   a_mag_in, b_mag_in, early_res, fix_res, quo_s, rem_s;

   assign ready_out = rst_n && ((state == IDLE) || (state == DONE && ready_in));
   assign valid_out = (state == DONE);
   assign busy_out  = (state == BUSY) || (state == FIX);
   assign accept    = valid_in && ready_out && !flush_in;

   assign a_neg_in  = a_signed(op_in) && a_in[XLEN-1];
   assign b_neg_in  = b_signed(op_in) && b_in[XLEN-1];
   assign a_mag_in  = a_neg_in ? -a_in : a_in;
   assign b_mag_in  = b_neg_in ? -b_in : b_in;
   assign early_hit = is_div(op_in) &&
                      ((b_in == '0) || (a_signed(op_in) && a_in == MIN_NEG && b_in == '1));
   assign early     = load && EARLY_OUT && early_hit;
   assign div_op    = is_div(op_q);

   // Architecturally mandated results for divide-by-zero and signed overflow.
   always_comb begin
      early_res = '0;
      case (op_in)
         DIV, DIVU: early_res = (b_in == '0) ? '1 : a_in;
         REM, REMU: early_res = (b_in == '0) ? a_in : '0;
         default:   early_res = '0;
      endcase
   end

   always_comb begin
      state_d = state;
      load    = 1'b0;
      step    = 1'b0;
      fix     = 1'b0;
      case (state)
         IDLE: if (accept) load = 1'b1;
         BUSY: begin
            step = 1'b1;
            if (cnt == '0) state_d = FIX;
         end
         FIX: begin
            fix     = 1'b1;
            state_d = DONE;
         end
         DONE: if (ready_in) begin
            state_d = IDLE;
            if (accept) load = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (load) state_d = (EARLY_OUT && early_hit) ? DONE : BUSY;
      if (flush_in) begin
         state_d = IDLE;
         load    = 1'b0;
         step    = 1'b0;
         fix     = 1'b0;
      end
   end

   // Sign correction: quotient/product take the XOR of operand signs, remainder follows the dividend.
   always_comb begin
      prod    = (a_neg ^ b_neg) ? -acc : acc;
      quo_s   = (a_neg ^ b_neg) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_s   = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      fix_res = rem_s;
      case (op_q)
         MUL:                fix_res = prod[XLEN-1:0];
         MULH, MULHSU, MULHU: fix_res = prod[2*XLEN-1:XLEN];
         DIV, DIVU:          fix_res = b_zero ? '1 : quo_s;
         default:            fix_res = rem_s;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         op_q       <= MUL;
         a_neg      <= 1'b0;
         b_neg      <= 1'b0;
         b_zero     <= 1'b0;
         rd_out     <= '0;
         result_out <= '0;
      end else begin
         state <= state_d;
         if (load) begin
            op_q   <= op_in;
            a_neg  <= a_neg_in;
            b_neg  <= b_neg_in;
            b_zero <= (b_in == '0);
            rd_out <= rd_in;
            cnt    <= CNT_W'(N - 1);
         end else if (step) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (early)
            result_out <= early_res;
         else if (fix)
            result_out <= fix_res;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         acc   <= {{XLEN{1'b0}}, a_mag_in};
         b_mag <= b_mag_in;
      end else if (step) begin
         acc <= acc_step;
      end
   end

   muldiv_step #(
      .XLEN           (XLEN),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .div      (div_op),
      .acc      (acc),
      .b        (b_mag),
      .acc_next (acc_step)
   );

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed table, corner sequences and random ops against a plain-arithmetic model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int XLEN = 32;
   localparam int BPC  = 1;
   localparam int N    = XLEN / BPC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_in;
   op_t         op_in;
   logic [31:0] a_in, b_in;
   logic [4:0]  rd_in;
   logic [1:0]  valid_in, ready_in, ready_out, valid_out, busy_out;
   logic [31:0] result_out [2];
   logic [4:0]  rd_out [2];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // Instance 0 uses early-out, instance 1 always iterates.
   muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC), .EARLY_OUT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .flush_in(flush_in), .valid_in(valid_in[0]), .ready_out(ready_out[0]),
      .op_in(op_in), .a_in(a_in), .b_in(b_in), .rd_in(rd_in), .valid_out(valid_out[0]),
      .ready_in(ready_in[0]), .result_out(result_out[0]), .rd_out(rd_out[0]), .busy_out(busy_out[0]));

   muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC), .EARLY_OUT(1'b0)) dut_ne (
      .clk(clk), .rst_n(rst_n), .flush_in(flush_in), .valid_in(valid_in[1]), .ready_out(ready_out[1]),
      .op_in(op_in), .a_in(a_in), .b_in(b_in), .rd_in(rd_in), .valid_out(valid_out[1]),
      .ready_in(ready_in[1]), .result_out(result_out[1]), .rd_out(rd_out[1]), .busy_out(busy_out[1]));

   typedef struct {
      op_t         op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          k;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_model(op_t op, logic [31:0] a, logic [31:0] b);
      longint          p;
      longint unsigned pu;
      int              q;
      pu = {32'b0, a} * {32'b0, b};
      p  = 0;
      q  = 0;
      case (op)
         MUL:    return pu[31:0];
         MULHU:  return pu[63:32];
         MULH: begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p[63:32];
         end
         MULHSU: begin
            p = longint'($signed(a)) * longint'({32'b0, b});
            return p[63:32];
         end
         DIV: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            q = $signed(a) / $signed(b);
            return q;
         end
         REM: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            q = $signed(a) % $signed(b);
            return q;
         end
         DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'($urandom_range(0, 9));
         default: return $urandom;
      endcase
   endfunction

   // k = index of the clock edge after the accept edge at which valid_out is first seen (0 = accept edge).
   task automatic run_op(input int d, input op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                         output int k);
      op_in = op; a_in = a; b_in = b; rd_in = rd;
      valid_in[d] = 1'b1;
      ready_in[d] = 1'b0;
      tick();
      valid_in[d] = 1'b0;
      k = 0;
      while (!valid_out[d] && k < 100) begin
         tick();
         k++;
      end
      res = result_out[d];
      rdo = rd_out[d];
      ready_in[d] = 1'b1;
      tick();
      ready_in[d] = 1'b0;
   endtask

   initial begin
      logic [31:0] res, exp;
      logic [4:0]  rdo, rd;
      int          k, seen;
      op_t         op;
      logic [31:0] a, b;

      vecs[0]  = '{MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, N + 1};
      vecs[1]  = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, N + 1};
      vecs[2]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, N + 1};
      vecs[3]  = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, N + 1};
      vecs[4]  = '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, N + 1};
      vecs[5]  = '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, N + 1};
      vecs[6]  = '{DIVU,   32'hFFFFFFFE, 32'd2,        32'h7FFFFFFF, N + 1};
      vecs[7]  = '{REMU,   32'd17,       32'd5,        32'd2,        N + 1};
      vecs[8]  = '{DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 0};
      vecs[9]  = '{REMU,   32'd5,        32'd0,        32'd5,        0};
      vecs[10] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
      vecs[11] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        0};

      rst_n = 1'b0; flush_in = 1'b0; op_in = MUL; a_in = '0; b_in = '0; rd_in = '0;
      valid_in = '0; ready_in = '0;
      #3;
      check("rst_ready_out", {31'b0, ready_out[0]}, 32'd0);
      check("rst_valid_out", {31'b0, valid_out[0]}, 32'd0);
      check("rst_busy_out",  {31'b0, busy_out[0]},  32'd0);
      check("rst_result",    result_out[0],          32'd0);
      check("rst_rd",        {27'b0, rd_out[0]},     32'd0);
      tick(); tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("idle_ready_out", {31'b0, ready_out[0]}, 32'd1);

      for (int i = 0; i < 12; i++) begin
         run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), res, rdo, k);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp);
         check($sformatf("vec%0d_rd", i), {27'b0, rdo}, 32'(i + 1));
         check($sformatf("vec%0d_latency", i), 32'(k), 32'(vecs[i].k));
      end

      for (int i = 8; i < 12; i++) begin
         run_op(1, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), res, rdo, k);
         check($sformatf("noearly%0d_result", i), res, vecs[i].exp);
         check($sformatf("noearly%0d_latency", i), 32'(k), 32'(N + 1));
      end

      // Backpressure, then back-to-back accept on the consuming edge.
      op_in = MULHU; a_in = 32'hFFFFFFFF; b_in = 32'hFFFFFFFF; rd_in = 5'd9;
      valid_in[0] = 1'b1;
      tick();
      valid_in[0] = 1'b0;
      k = 0;
      while (!valid_out[0] && k < 100) begin tick(); k++; end
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_result", result_out[0], 32'hFFFFFFFE);
         check("bp_rd", {27'b0, rd_out[0]}, 32'd9);
         check("bp_ready_out", {31'b0, ready_out[0]}, 32'd0);
      end
      op_in = DIVU; a_in = 32'd100; b_in = 32'd7; rd_in = 5'd3;
      valid_in[0] = 1'b1; ready_in[0] = 1'b1;
      #1;
      check("b2b_ready_out", {31'b0, ready_out[0]}, 32'd1);
      tick();
      valid_in[0] = 1'b0; ready_in[0] = 1'b0;
      check("b2b_valid_low", {31'b0, valid_out[0]}, 32'd0);
      check("b2b_busy", {31'b0, busy_out[0]}, 32'd1);
      k = 0;
      while (!valid_out[0] && k < 100) begin tick(); k++; end
      check("b2b_latency", 32'(k), 32'(N + 1));
      check("b2b_result", result_out[0], 32'd14);
      check("b2b_rd", {27'b0, rd_out[0]}, 32'd3);
      ready_in[0] = 1'b1; tick(); ready_in[0] = 1'b0;

      // Flush in the 10th BUSY cycle of a divide.
      op_in = DIV; a_in = 32'd1000; b_in = 32'd3; rd_in = 5'd4;
      valid_in[0] = 1'b1;
      tick();
      valid_in[0] = 1'b0;
      repeat (9) tick();
      check("flush_busy_before", {31'b0, busy_out[0]}, 32'd1);
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      check("flush_busy_after", {31'b0, busy_out[0]}, 32'd0);
      check("flush_valid_after", {31'b0, valid_out[0]}, 32'd0);
      check("flush_ready_out", {31'b0, ready_out[0]}, 32'd1);
      seen = 0;
      repeat (40) begin
         tick();
         if (valid_out[0]) seen = 1;
      end
      check("flush_valid_never", 32'(seen), 32'd0);
      run_op(0, DIV, 32'd1000, 32'd3, 5'd4, res, rdo, k);
      check("post_flush_result", res, 32'd333);

      for (int i = 0; i < 40; i++) begin
         op = op_t'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         rd = 5'($urandom_range(0, 31));
         exp = ref_model(op, a, b);
         run_op(i % 2, op, a, b, rd, res, rdo, k);
         check($sformatf("rand%0d_%s_result", i, op.name()), res, exp);
         check($sformatf("rand%0d_rd", i), {27'b0, rdo}, {27'b0, rd});
      end

      // Asynchronous reset in the middle of a multiply.
      run_op(0, DIV, 32'd1000, 32'd3, 5'd4, res, rdo, k);
      op_in = MUL; a_in = 32'd7; b_in = 32'd9; rd_in = 5'd2;
      valid_in[0] = 1'b1;
      tick();
      valid_in[0] = 1'b0;
      repeat (5) tick();
      check("mid_mul_busy", {31'b0, busy_out[0]}, 32'd1);
      check("mid_mul_result_held", result_out[0], 32'd333);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", {31'b0, valid_out[0]}, 32'd0);
      check("async_rst_busy", {31'b0, busy_out[0]}, 32'd0);
      check("async_rst_result", result_out[0], 32'd0);
      check("async_rst_ready", {31'b0, ready_out[0]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_ready", {31'b0, ready_out[0]}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
